// File: rtl/spectrum_pkg.sv
// Shared constants and types for the Spectrum core I/O stage.
package spectrum_pkg;

    // ULA port is selected by A0 alone
    localparam logic ULA_PORT_A0 = 1'b0;

    // 48K frame timing
    localparam int unsigned T_FRAME_48K   = 69888;
    localparam int unsigned INT_LEN_48K   = 32;
    localparam int unsigned FLASH_DIV_48K = 16;

    // Bit positions in the port 0xFE data byte
    localparam int unsigned BORDER_LSB = 0;
    localparam int unsigned BORDER_MSB = 2;
    localparam int unsigned MIC_BIT    = 3;
    localparam int unsigned BEEP_BIT   = 4;
    localparam int unsigned EAR_BIT    = 6;

    // Fields latched by an OUT to port 0xFE
    typedef struct packed {
        logic       beeper;
        logic       mic;
        logic [2:0] border;
    } ula_out_t;

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry out of a DAC_W-bit phase
// accumulator gives a 1-bit stream whose density is level / 2**DAC_W.
module sigma_delta_dac #(
    parameter int unsigned DAC_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DAC_W-1:0] level,
    output logic             out
);

    logic [DAC_W:0] acc_q, acc_d;
    logic           out_q;

    // Next accumulator value: low bits plus level, carry lands in the MSB
    always_comb begin
        acc_d = {1'b0, acc_q[DAC_W-1:0]} + {1'b0, level};
    end

    // Accumulator and registered carry output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            out_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            out_q <= acc_d[DAC_W];
        end
    end

    assign out = out_q;

endmodule

// File: rtl/ula_io_port.sv
// ULA-side I/O stage: port 0xFE decode, border/MIC/beeper latch, keyboard/EAR
// read path, frame T-state counter with n_int and FLASH phase, 1-bit audio.
module ula_io_port
    import spectrum_pkg::*;
#(
    parameter int unsigned T_FRAME   = T_FRAME_48K,
    parameter int unsigned INT_LEN   = INT_LEN_48K,
    parameter int unsigned FLASH_DIV = FLASH_DIV_48K,
    parameter int unsigned DAC_W     = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic [4:0]  key_data,
    input  logic        ear_in,
    output logic [7:0]  io_dout,
    output logic        io_sel,
    output logic [2:0]  border,
    output logic        flash,
    output logic        n_int,
    output logic        audio_out
);

    localparam int unsigned TS_W = $clog2(T_FRAME);
    localparam int unsigned FC_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    localparam logic [DAC_W-1:0] BEEP_LVL = DAC_W'(3 << (DAC_W - 2));
    localparam logic [DAC_W-1:0] MIC_LVL  = DAC_W'(1 << (DAC_W - 2));

    logic            sel;
    logic            wr_act;
    logic            wr_act_q, wr_act_q2;
    logic            wr_rise;
    logic            ear_meta_q, ear_s_q;
    ula_out_t        port_q;
    logic [TS_W-1:0] tstate_q;
    logic [FC_W-1:0] frame_q;
    logic            flash_q;
    logic            n_int_q;
    logic [DAC_W-1:0] level;

    // A15..A1 and D7..D5 are deliberately not decoded
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[15:1], cpu_dout[7:5]};

    assign sel     = !n_iorq && (cpu_addr[0] == ULA_PORT_A0);
    assign wr_act  = sel && !n_wr;
    assign wr_rise = wr_act_q && !wr_act_q2;

    assign io_sel  = sel && !n_rd;
    assign io_dout = {1'b1, ear_s_q, 1'b1, key_data};

    // EAR synchroniser and write-strobe edge detector
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ear_meta_q <= 1'b0;
            ear_s_q    <= 1'b0;
            wr_act_q   <= 1'b0;
            wr_act_q2  <= 1'b0;
        end else begin
            ear_meta_q <= ear_in;
            ear_s_q    <= ear_meta_q;
            wr_act_q   <= wr_act;
            wr_act_q2  <= wr_act_q;
        end
    end

    // Port 0xFE output latch: one update per write, however long it is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q <= '0;
        end else if (wr_rise) begin
            port_q.border <= cpu_dout[BORDER_MSB:BORDER_LSB];
            port_q.mic    <= cpu_dout[MIC_BIT];
            port_q.beeper <= cpu_dout[BEEP_BIT];
        end
    end

    // Frame timing: T-state counter, interrupt window, flash divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tstate_q <= '0;
            frame_q  <= '0;
            flash_q  <= 1'b0;
            n_int_q  <= 1'b1;
        end else if (cpu_ce) begin
            // n_int reflects the T-state being consumed by this cpu_ce
            n_int_q <= !(tstate_q < TS_W'(INT_LEN));
            if (tstate_q == TS_W'(T_FRAME - 1)) begin
                tstate_q <= '0;
                if (frame_q == FC_W'(FLASH_DIV - 1)) begin
                    frame_q <= '0;
                    flash_q <= !flash_q;
                end else begin
                    frame_q <= frame_q + 1'b1;
                end
            end else begin
                tstate_q <= tstate_q + 1'b1;
            end
        end
    end

    // Audio level: beeper 3/4, mic 1/4, both saturate just below full scale
    always_comb begin
        level = '0;
        unique case ({port_q.beeper, port_q.mic})
            2'b00:   level = '0;
            2'b01:   level = MIC_LVL;
            2'b10:   level = BEEP_LVL;
            default: level = '1;
        endcase
    end

    sigma_delta_dac #(
        .DAC_W (DAC_W)
    ) u_dac (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .out     (audio_out)
    );

    assign border = port_q.border;
    assign flash  = flash_q;
    assign n_int  = n_int_q;

endmodule

// File: tb/tb_ula_io_port.sv
// Self-checking bench for ula_io_port with a shortened frame so that
// 32 frames fit in a short run.
module tb_ula_io_port;

    localparam int unsigned T_FRAME   = 300;
    localparam int unsigned INT_LEN   = 32;
    localparam int unsigned FLASH_DIV = 16;
    localparam int unsigned DAC_W     = 8;

    logic        clk;
    logic        reset_n;
    logic        cpu_ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        n_iorq;
    logic        n_rd;
    logic        n_wr;
    logic [4:0]  key_data;
    logic        ear_in;
    logic [7:0]  io_dout;
    logic        io_sel;
    logic [2:0]  border;
    logic        flash;
    logic        n_int;
    logic        audio_out;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned ce_cnt;
    logic [2:0]  border_m;

    ula_io_port #(
        .T_FRAME   (T_FRAME),
        .INT_LEN   (INT_LEN),
        .FLASH_DIV (FLASH_DIV),
        .DAC_W     (DAC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_ce    (cpu_ce),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .n_iorq    (n_iorq),
        .n_rd      (n_rd),
        .n_wr      (n_wr),
        .key_data  (key_data),
        .ear_in    (ear_in),
        .io_dout   (io_dout),
        .io_sel    (io_sel),
        .border    (border),
        .flash     (flash),
        .n_int     (n_int),
        .audio_out (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = !clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: after n T-state strobes, the last consumed T-state is (n-1) mod T_FRAME
    function automatic logic model_n_int(input int unsigned n);
        if (n == 0) return 1'b1;
        return !(((n - 1) % T_FRAME) < INT_LEN);
    endfunction

    function automatic logic model_flash(input int unsigned n);
        return 1'((n / T_FRAME / FLASH_DIV) % 2);
    endfunction

    function automatic int unsigned model_level(input logic beep, input logic mic);
        int unsigned l;
        l = (beep ? 3 : 0) * (1 << (DAC_W - 2)) + (mic ? 1 : 0) * (1 << (DAC_W - 2));
        if (l > (1 << DAC_W) - 1) l = (1 << DAC_W) - 1;
        return l;
    endfunction

    // One clock; inputs change and outputs are sampled 1 unit after the edge
    task automatic step(input logic ce);
        cpu_ce = ce;
        @(posedge clk);
        #1;
        cpu_ce = 1'b0;
        if (ce && reset_n) ce_cnt++;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data,
                             input int unsigned hold, input logic ce);
        cpu_addr = addr;
        cpu_dout = data;
        n_iorq   = 1'b0;
        n_wr     = 1'b0;
        repeat (hold) step(ce);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        step(ce);
        step(ce);
        if (addr[0] == 1'b0) border_m = data[2:0];
    endtask

    task automatic count_audio(input int unsigned n, output int unsigned c);
        c = 0;
        repeat (n) begin
            step(1'b0);
            c += 32'(audio_out);
        end
    endtask

    task automatic dac_case(input string tag, input logic [7:0] data);
        int unsigned c, e, tol;
        bus_write(16'h00FE, data, 2, 1'b0);
        repeat (4) step(1'b0);
        count_audio(1024, c);
        e   = model_level(data[4], data[3]) * 1024 / (1 << DAC_W);
        tol = (e == 0) ? 0 : 1;
        check_eq(tag, 32'((c + tol >= e) && (c <= e + tol)), 32'd1);
        if (!((c + tol >= e) && (c <= e + tol))) $display("  %s count %0d, want %0d", tag, c, e);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned lows [2];
        int unsigned falls [2];
        int unsigned n_falls;
        logic        prev_n_int;
        logic        a0;
        logic        rd;
        logic        iorq;

        n_vec    = 0;
        n_err    = 0;
        ce_cnt   = 0;
        border_m = 3'd0;
        reset_n  = 1'b0;
        cpu_ce   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        n_iorq   = 1'b1;
        n_rd     = 1'b1;
        n_wr     = 1'b1;
        key_data = 5'h1F;
        ear_in   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_n_int", 32'(n_int), 32'd1);
        check_eq("rst_border", 32'(border), 32'd0);
        check_eq("rst_flash", 32'(flash), 32'd0);
        check_eq("rst_audio", 32'(audio_out), 32'd0);
        check_eq("rst_io_sel", 32'(io_sel), 32'd0);
        reset_n = 1'b1;
        step(1'b0);
        step(1'b0);

        // OUT (0xFE),0x15 held 5 clks, data changed after the latch point
        cpu_addr = 16'h12FE;
        cpu_dout = 8'h15;
        n_iorq   = 1'b0;
        n_wr     = 1'b0;
        step(1'b0);
        check_eq("wr_lat1", 32'(border), 32'd0);
        step(1'b0);
        check_eq("wr_lat2", 32'(border), 32'd5);
        step(1'b0);
        cpu_dout = 8'h0A;
        step(1'b0);
        step(1'b0);
        n_iorq = 1'b1;
        n_wr   = 1'b1;
        step(1'b0);
        step(1'b0);
        check_eq("wr_once", 32'(border), 32'd5);
        border_m = 3'd5;

        // Audio density: beeper only, silent, mic only, both
        repeat (4) step(1'b0);
        begin
            int unsigned c;
            count_audio(1024, c);
            check_eq("dac_beep_held", 32'((c >= 767) && (c <= 769)), 32'd1);
        end
        dac_case("dac_zero", 8'h00);
        dac_case("dac_mic", 8'h08);
        dac_case("dac_both", 8'h18);
        dac_case("dac_beep", 8'h10);
        border_m = 3'd0;

        // IN A,(0xFE)
        key_data = 5'b10110;
        ear_in   = 1'b1;
        repeat (3) step(1'b0);
        cpu_addr = 16'h00FE;
        n_iorq   = 1'b0;
        n_rd     = 1'b0;
        #1;
        check_eq("rd_sel", 32'(io_sel), 32'd1);
        check_eq("rd_data", 32'(io_dout), 32'hF6);
        cpu_addr = 16'h00FF;
        #1;
        check_eq("rd_a0_sel", 32'(io_sel), 32'd0);
        check_eq("rd_a0_data", 32'(io_dout), 32'hF6);
        n_iorq = 1'b1;
        n_rd   = 1'b1;
        step(1'b0);

        // Randomised reads
        for (int i = 0; i < 24; i++) begin
            logic [4:0] k;
            logic       e;
            k        = 5'($urandom);
            e        = 1'($urandom);
            key_data = k;
            ear_in   = e;
            repeat (3) step(1'b0);
            a0       = 1'($urandom);
            rd       = 1'($urandom);
            iorq     = 1'($urandom_range(0, 3) == 0);
            cpu_addr = {15'($urandom), a0};
            n_rd     = rd;
            n_iorq   = iorq;
            #1;
            check_eq("rnd_rd_sel", 32'(io_sel), 32'(!iorq && !a0 && !rd));
            check_eq("rnd_rd_data", 32'(io_dout), 32'({1'b1, e, 1'b1, k}));
            n_rd   = 1'b1;
            n_iorq = 1'b1;
            step(1'b0);
        end

        // Randomised writes, some to odd ports
        for (int i = 0; i < 24; i++) begin
            bus_write(16'($urandom), 8'($urandom), $urandom_range(1, 4), 1'b0);
            check_eq("rnd_wr_border", 32'(border), 32'(border_m));
        end

        // Reset asserted between clock edges while n_int is low
        bus_write(16'h00FE, 8'h17, 2, 1'b0);
        ce_cnt = 0;
        repeat (10) step(1'b1);
        check_eq("pre_rst_n_int", 32'(n_int), 32'd0);
        check_eq("pre_rst_border", 32'(border), 32'd7);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_n_int", 32'(n_int), 32'd1);
        check_eq("async_border", 32'(border), 32'd0);
        check_eq("async_audio", 32'(audio_out), 32'd0);
        step(1'b0);
        reset_n  = 1'b1;
        ce_cnt   = 0;
        border_m = 3'd0;
        step(1'b0);
        step(1'b0);
        check_eq("post_rst_wait_ce", 32'(n_int), 32'd1);

        // Two frames, cpu_ce every 5 clks
        lows[0]    = 0;
        lows[1]    = 0;
        n_falls    = 0;
        prev_n_int = 1'b1;
        for (int i = 0; i < 2 * T_FRAME; i++) begin
            step(1'b1);
            check_eq("int_frame", 32'(n_int), 32'(model_n_int(ce_cnt)));
            if (!n_int) lows[(ce_cnt - 1) / T_FRAME]++;
            if (prev_n_int && !n_int && n_falls < 2) begin
                falls[n_falls] = ce_cnt;
                n_falls++;
            end
            prev_n_int = n_int;
            repeat (4) step(1'b0);
        end
        check_eq("int_len_f0", lows[0], INT_LEN);
        check_eq("int_len_f1", lows[1], INT_LEN);
        check_eq("int_falls", n_falls, 32'd2);
        check_eq("int_period", falls[1] - falls[0], T_FRAME);

        // Run to 32 frames with random gaps; one write straddles a frame wrap
        while (ce_cnt < 32 * T_FRAME + 5) begin
            if (ce_cnt == 3 * T_FRAME - 2) begin
                bus_write(16'h00FE, 8'($urandom), 3, 1'b1);
                check_eq("wrap_wr_border", 32'(border), 32'(border_m));
            end else begin
                step(1'b1);
                repeat ($urandom_range(0, 2)) step(1'b0);
            end
            check_eq("run_n_int", 32'(n_int), 32'(model_n_int(ce_cnt)));
            check_eq("run_flash", 32'(flash), 32'(model_flash(ce_cnt)));
            if (ce_cnt == 16 * T_FRAME) check_eq("flash_f16", 32'(flash), 32'd1);
        end
        check_eq("flash_f32", 32'(flash), 32'd0);

        // No cpu_ce: everything holds, including n_int inside its window
        repeat (50) step(1'b0);
        check_eq("freeze_n_int", 32'(n_int), 32'd0);
        check_eq("freeze_flash", 32'(flash), 32'(model_flash(ce_cnt)));
        step(1'b1);
        check_eq("resume_n_int", 32'(n_int), 32'(model_n_int(ce_cnt)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
